// File: rtl/vx_tcu_uop_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vx_tcu_uop_seq_pkg
//  Description : Shared TCU constants, FSM state encoding, uop record and
//                small elaboration helpers for the WMMA micro-op sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package vx_tcu_uop_seq_pkg;

    // Default tile geometry (all step and sub-block counts are powers of two)
    localparam int TCU_M_STEPS      = 2;
    localparam int TCU_N_STEPS      = 4;
    localparam int TCU_K_STEPS      = 4;
    localparam int TCU_A_SUB_BLOCKS = 1;
    localparam int TCU_B_SUB_BLOCKS = 2;

    // Register file bases for the A, B and C operand ranges
    localparam int TCU_RA           = 0;
    localparam int TCU_RB           = 10;
    localparam int TCU_RC           = 24;

    localparam int TCU_REG_BITS     = 5;
    localparam int TCU_UUID_BITS    = 44;
    localparam int TCU_NW_BITS      = 2;

    localparam int TCU_UOPS         = TCU_M_STEPS * TCU_N_STEPS * TCU_K_STEPS;

    // Index width for a count of n items; a single item still needs one bit
    function automatic int tcu_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TCU_MW = tcu_w(TCU_M_STEPS);
    localparam int TCU_NW = tcu_w(TCU_N_STEPS);
    localparam int TCU_KW = tcu_w(TCU_K_STEPS);
    localparam int TCU_AW = tcu_w(TCU_A_SUB_BLOCKS);
    localparam int TCU_BW = tcu_w(TCU_B_SUB_BLOCKS);

    // True when the closed intervals [lo0,hi0] and [lo1,hi1] share a value
    function automatic bit tcu_overlap(input int lo0, input int hi0,
                                       input int lo1, input int hi1);
        return !((hi0 < lo1) || (hi1 < lo0));
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } tcu_seq_state_t;

    // One micro-op of the default tile configuration
    typedef struct packed {
        logic [TCU_MW-1:0]       step_m;
        logic [TCU_NW-1:0]       step_n;
        logic [TCU_KW-1:0]       step_k;
        logic [TCU_REG_BITS-1:0] rs1;
        logic [TCU_REG_BITS-1:0] rs2;
        logic [TCU_REG_BITS-1:0] rs3;
        logic [TCU_AW-1:0]       a_sub;
        logic [TCU_BW-1:0]       b_sub;
        logic                    first_k;
        logic                    last_k;
        logic                    last;
    } tcu_uop_t;

endpackage
`default_nettype wire

// File: rtl/vx_tcu_step_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : vx_tcu_step_ctr
//  Description : Nested m/n/k wrap counter (k innermost) with synchronous
//                clear and advance enable; reports k==0, k==last and the
//                final step of the whole tile.
//  Revision    : 1.0 - initial release
// ============================================================================
module vx_tcu_step_ctr
    import vx_tcu_uop_seq_pkg::*;
#(
    parameter int M_STEPS = TCU_M_STEPS,
    parameter int N_STEPS = TCU_N_STEPS,
    parameter int K_STEPS = TCU_K_STEPS,
    localparam int MW     = tcu_w(M_STEPS),
    localparam int NW     = tcu_w(N_STEPS),
    localparam int KW     = tcu_w(K_STEPS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          en,
    output logic [MW-1:0] m,
    output logic [NW-1:0] n,
    output logic [KW-1:0] k,
    output logic          first_k,
    output logic          last_k,
    output logic          last
);

    localparam logic [MW-1:0] M_LAST = MW'(M_STEPS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_STEPS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K_STEPS - 1);

    logic [MW-1:0] m_q, m_d;
    logic [NW-1:0] n_q, n_d;
    logic [KW-1:0] k_q, k_d;

    // Next-step computation: clear wins over advance so a newly accepted
    // instruction always restarts at (0,0,0)
    always_comb begin
        m_d = m_q;
        n_d = n_q;
        k_d = k_q;
        if (clr) begin
            m_d = '0;
            n_d = '0;
            k_d = '0;
        end else if (en) begin
            if (k_q == K_LAST) begin
                k_d = '0;
                if (n_q == N_LAST) begin
                    n_d = '0;
                    m_d = (m_q == M_LAST) ? '0 : m_q + MW'(1);
                end else begin
                    n_d = n_q + NW'(1);
                end
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    // Counter state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q <= '0;
            n_q <= '0;
            k_q <= '0;
        end else begin
            m_q <= m_d;
            n_q <= n_d;
            k_q <= k_d;
        end
    end

    assign m       = m_q;
    assign n       = n_q;
    assign k       = k_q;
    assign first_k = (k_q == '0);
    assign last_k  = (k_q == K_LAST);
    assign last    = (k_q == K_LAST) && (n_q == N_LAST) && (m_q == M_LAST);

endmodule
`default_nettype wire

// File: rtl/vx_tcu_uop_seq.sv
`default_nettype none
// ============================================================================
//  Module      : vx_tcu_uop_seq
//  Description : WMMA micro-op sequencer. Accepts one instruction per
//                handshake, expands it into M*N*K micro-ops in (m,n,k) order
//                with register / sub-block mapping, and streams them to the
//                TCU execute lanes. Back-to-back instructions issue with no
//                bubble by accepting on the final uop handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module vx_tcu_uop_seq
    import vx_tcu_uop_seq_pkg::*;
#(
    parameter int M_STEPS      = TCU_M_STEPS,
    parameter int N_STEPS      = TCU_N_STEPS,
    parameter int K_STEPS      = TCU_K_STEPS,
    parameter int A_SUB_BLOCKS = TCU_A_SUB_BLOCKS,
    parameter int B_SUB_BLOCKS = TCU_B_SUB_BLOCKS,
    parameter int RA           = TCU_RA,
    parameter int RB           = TCU_RB,
    parameter int RC           = TCU_RC,
    parameter int REG_BITS     = TCU_REG_BITS,
    parameter int UUID_BITS    = TCU_UUID_BITS,
    parameter int NW_BITS      = TCU_NW_BITS,
    localparam int MW          = tcu_w(M_STEPS),
    localparam int NW          = tcu_w(N_STEPS),
    localparam int KW          = tcu_w(K_STEPS),
    localparam int AW          = tcu_w(A_SUB_BLOCKS),
    localparam int BW          = tcu_w(B_SUB_BLOCKS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [UUID_BITS-1:0] in_uuid,
    input  logic [NW_BITS-1:0]   in_wid,
    input  logic [3:0]           in_fmt_s,
    input  logic [3:0]           in_fmt_d,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [UUID_BITS-1:0] out_uuid,
    output logic [NW_BITS-1:0]   out_wid,
    output logic [3:0]           out_fmt_s,
    output logic [3:0]           out_fmt_d,
    output logic [MW-1:0]        out_step_m,
    output logic [NW-1:0]        out_step_n,
    output logic [KW-1:0]        out_step_k,
    output logic [REG_BITS-1:0]  out_rs1,
    output logic [REG_BITS-1:0]  out_rs2,
    output logic [REG_BITS-1:0]  out_rs3,
    output logic [AW-1:0]        out_a_sub,
    output logic [BW-1:0]        out_b_sub,
    output logic                 out_first_k,
    output logic                 out_last_k,
    output logic                 out_last,
    output logic                 busy
);

    // Sub-block counts are powers of two, so divide/modulo become shift/mask
    localparam int A_SH    = $clog2(A_SUB_BLOCKS);
    localparam int B_SH    = $clog2(B_SUB_BLOCKS);

    // Register range bounds used by the elaboration-time configuration check
    localparam int REG_MAX = (1 << REG_BITS) - 1;
    localparam int RS1_MAX = RA + ((M_STEPS * K_STEPS - 1) >> A_SH);
    localparam int RS2_MAX = RB + ((N_STEPS * K_STEPS - 1) >> B_SH);
    localparam int RS3_MAX = RC + M_STEPS * N_STEPS - 1;
    localparam bit CFG_OK  = (RS1_MAX <= REG_MAX) && (RS2_MAX <= REG_MAX) &&
                             (RS3_MAX <= REG_MAX) &&
                             !tcu_overlap(RA, RS1_MAX, RB, RS2_MAX) &&
                             !tcu_overlap(RA, RS1_MAX, RC, RS3_MAX) &&
                             !tcu_overlap(RB, RS2_MAX, RC, RS3_MAX);

    generate
        if (!CFG_OK) begin : g_cfg_bad
            $error("vx_tcu_uop_seq: A/B/C register ranges overflow REG_BITS or overlap");
        end
    endgenerate

    tcu_seq_state_t         state_q, state_d;
    logic [UUID_BITS-1:0]   uuid_q, uuid_d;
    logic [NW_BITS-1:0]     wid_q, wid_d;
    logic [3:0]             fmt_s_q, fmt_s_d;
    logic [3:0]             fmt_d_q, fmt_d_d;

    logic                   issuing;
    logic                   fire_out;
    logic                   accept;

    logic [MW-1:0]          ctr_m;
    logic [NW-1:0]          ctr_n;
    logic [KW-1:0]          ctr_k;
    logic                   ctr_first_k;
    logic                   ctr_last_k;
    logic                   ctr_last;

    int                     a_idx;
    int                     b_idx;

    assign issuing   = (state_q == ST_ISSUE);
    assign out_valid = issuing;
    assign busy      = issuing;
    assign fire_out  = issuing & out_ready;
    // Re-open the input on the final uop handshake so the next instruction
    // follows without a bubble; this is a deliberate out_ready->in_ready path
    assign in_ready  = !issuing | (fire_out & ctr_last);
    assign accept    = in_valid & in_ready;

    vx_tcu_step_ctr #(
        .M_STEPS (M_STEPS),
        .N_STEPS (N_STEPS),
        .K_STEPS (K_STEPS)
    ) u_step_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .en      (fire_out),
        .m       (ctr_m),
        .n       (ctr_n),
        .k       (ctr_k),
        .first_k (ctr_first_k),
        .last_k  (ctr_last_k),
        .last    (ctr_last)
    );

    // Next-state and instruction field latching
    always_comb begin
        state_d = state_q;
        uuid_d  = uuid_q;
        wid_d   = wid_q;
        fmt_s_d = fmt_s_q;
        fmt_d_d = fmt_d_q;
        if (accept) begin
            state_d = ST_ISSUE;
            uuid_d  = in_uuid;
            wid_d   = in_wid;
            fmt_s_d = in_fmt_s;
            fmt_d_d = in_fmt_d;
        end else if (fire_out && ctr_last) begin
            state_d = ST_IDLE;
        end
    end

    // Sequencer FSM and latched instruction fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            uuid_q  <= '0;
            wid_q   <= '0;
            fmt_s_q <= '0;
            fmt_d_q <= '0;
        end else begin
            state_q <= state_d;
            uuid_q  <= uuid_d;
            wid_q   <= wid_d;
            fmt_s_q <= fmt_s_d;
            fmt_d_q <= fmt_d_d;
        end
    end

    // Uop field mapping; every data field reads zero while no uop is valid
    always_comb begin
        a_idx       = int'(ctr_m) * K_STEPS + int'(ctr_k);
        b_idx       = int'(ctr_n) * K_STEPS + int'(ctr_k);
        out_uuid    = '0;
        out_wid     = '0;
        out_fmt_s   = '0;
        out_fmt_d   = '0;
        out_step_m  = '0;
        out_step_n  = '0;
        out_step_k  = '0;
        out_rs1     = '0;
        out_rs2     = '0;
        out_rs3     = '0;
        out_a_sub   = '0;
        out_b_sub   = '0;
        out_first_k = 1'b0;
        out_last_k  = 1'b0;
        out_last    = 1'b0;
        if (issuing) begin
            out_uuid    = uuid_q;
            out_wid     = wid_q;
            out_fmt_s   = fmt_s_q;
            out_fmt_d   = fmt_d_q;
            out_step_m  = ctr_m;
            out_step_n  = ctr_n;
            out_step_k  = ctr_k;
            out_rs1     = REG_BITS'(RA + (a_idx >> A_SH));
            out_rs2     = REG_BITS'(RB + (b_idx >> B_SH));
            out_rs3     = REG_BITS'(RC + int'(ctr_m) * N_STEPS + int'(ctr_n));
            out_a_sub   = AW'(a_idx & (A_SUB_BLOCKS - 1));
            out_b_sub   = BW'(b_idx & (B_SUB_BLOCKS - 1));
            out_first_k = ctr_first_k;
            out_last_k  = ctr_last_k;
            out_last    = ctr_last;
        end
    end

endmodule
`default_nettype wire
